// File: rtl/mem_responder_if.sv
// Doubleword memory bus between the core (master) and the responder (slave).
// Two read ports, one posted write port and write-buffer status.
interface mem_responder_if #(parameter int WBUF_DEPTH = 4);
  localparam int CW = $clog2(WBUF_DEPTH) + 1;

  logic          readEn0;
  logic [0:60]   readAddr0;
  logic [0:63]   readData0;
  logic          readEn1;
  logic [0:60]   readAddr1;
  logic [0:63]   readData1;
  logic          writeEn;
  logic [0:60]   writeAddr;
  logic [0:63]   writeData;
  logic          wbFull;
  logic [CW-1:0] wbCount;
  logic          wbOverflow;

  modport master (
    output readEn0, readAddr0, readEn1, readAddr1, writeEn, writeAddr, writeData,
    input  readData0, readData1, wbFull, wbCount, wbOverflow
  );

  modport slave (
    input  readEn0, readAddr0, readEn1, readAddr1, writeEn, writeAddr, writeData,
    output readData0, readData1, wbFull, wbCount, wbOverflow
  );
endinterface

// File: rtl/mem_responder.sv
// Memory responder: 1-cycle reads with store forwarding, posted stores in an
// in-order write buffer drained to the backing array on read-idle cycles.
module mem_responder #(
  parameter int IDX_BITS   = 10,
  parameter int WBUF_DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  mem_responder_if.slave bus
);
  localparam int PW      = $clog2(WBUF_DEPTH);
  localparam int CW      = PW + 1;
  localparam int ENTRIES = 1 << IDX_BITS;

  typedef logic [IDX_BITS-1:0] idx_t;
  typedef logic [0:63]         data_t;

  data_t         mem    [ENTRIES];
  idx_t          wbIdx  [WBUF_DEPTH];
  data_t         wbData [WBUF_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          full, accept, drain, overflow;
  logic          readEn0, readEn1, writeEn;
  idx_t          rIdx0, rIdx1, wIdx;
  data_t         writeData, fwd0, fwd1, rd0, rd1;
  logic          unusedAddrBits;

  // Only the low IDX_BITS of each address select a doubleword; upper bits alias.
  assign rIdx0     = bus.readAddr0[61-IDX_BITS:60];
  assign rIdx1     = bus.readAddr1[61-IDX_BITS:60];
  assign wIdx      = bus.writeAddr[61-IDX_BITS:60];
  assign readEn0   = bus.readEn0;
  assign readEn1   = bus.readEn1;
  assign writeEn   = bus.writeEn;
  assign writeData = bus.writeData;
  assign unusedAddrBits = ^{bus.readAddr0[0:60-IDX_BITS], bus.readAddr1[0:60-IDX_BITS],
                            bus.writeAddr[0:60-IDX_BITS]};

  assign full   = (count == CW'(WBUF_DEPTH));
  assign accept = writeEn && !full;
  assign drain  = (count != '0) && !readEn0 && !readEn1;

  // Oldest-to-youngest scan so the youngest buffered match wins; a same-cycle store beats all.
  function automatic data_t lookup(input idx_t r);
    data_t         v;
    logic [PW-1:0] pos;
    v = mem[r];
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      pos = head + PW'(i);
      if ((CW'(i) < count) && (wbIdx[pos] == r)) v = wbData[pos];
    end
    if (accept && (wIdx == r)) v = writeData;
    return v;
  endfunction

  always_comb begin
    fwd0 = lookup(rIdx0);
    fwd1 = lookup(rIdx1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd0      <= '0;
      rd1      <= '0;
    end else begin
      if (readEn0) rd0 <= fwd0;
      if (readEn1) rd1 <= fwd1;
      if (writeEn && full) overflow <= 1'b1;
      if (accept) begin
        wbIdx[tail]  <= wIdx;
        wbData[tail] <= writeData;
        tail         <= tail + 1'b1;
      end
      if (drain) head <= head + 1'b1;
      count <= count + CW'(accept) - CW'(drain);
    end
  end

  // Array is never cleared; a reset simply abandons whatever is still buffered.
  always_ff @(posedge clk) begin
    if (!reset && drain) mem[wbIdx[head]] <= wbData[head];
  end

  assign bus.readData0  = rd0;
  assign bus.readData1  = rd1;
  assign bus.wbFull     = full;
  assign bus.wbCount    = count;
  assign bus.wbOverflow = overflow;
endmodule
